// File: rtl/mips_pkg.sv
// Shared definitions for the instruction-fetch side of the core.
//   INSTR_W            instruction word width
//   NOP_INSTR          word returned for fetches outside the instruction RAM
//   DEFAULT_ADDR_W     default fetch address width (word addresses)
//   DEFAULT_DEPTH_LOG2 default log2 of instruction RAM depth in words
package mips_pkg;

    localparam int INSTR_W = 32;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;
    localparam int DEFAULT_ADDR_W = 32;
    localparam int DEFAULT_DEPTH_LOG2 = 10;

endpackage

// File: rtl/imem_fetch_responder_if.sv
// Fetch-side bus between the fetch stage (master) and the instruction memory
// responder (slave).
//   req_valid/req_ready/req_addr       fetch request channel
//   resp_valid/resp_ready/resp_*       response channel (data, addr, err)
//   flush                              redirect: drop everything outstanding
//   ld_en/ld_addr/ld_data              program-load write port
//
// Handshake: a channel transfers on a rising clk edge where valid and ready
// are both high. A producer holding valid keeps its payload stable until the
// transfer; ready may depend combinationally on the consumer's own state but
// never on valid. flush overrides both channels for the cycle it is high.
interface imem_fetch_responder_if
    import mips_pkg::*;
#(
    parameter int ADDR_W     = DEFAULT_ADDR_W,
    parameter int DEPTH_LOG2 = DEFAULT_DEPTH_LOG2
) ();

    logic                  req_valid;
    logic                  req_ready;
    logic [ADDR_W-1:0]     req_addr;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [INSTR_W-1:0]    resp_data;
    logic [ADDR_W-1:0]     resp_addr;
    logic                  resp_err;
    logic                  flush;
    logic                  ld_en;
    logic [DEPTH_LOG2-1:0] ld_addr;
    logic [INSTR_W-1:0]    ld_data;

    modport master (
        output req_valid, req_addr, resp_ready, flush, ld_en, ld_addr, ld_data,
        input  req_ready, resp_valid, resp_data, resp_addr, resp_err
    );

    modport slave (
        input  req_valid, req_addr, resp_ready, flush, ld_en, ld_addr, ld_data,
        output req_ready, resp_valid, resp_data, resp_addr, resp_err
    );

endinterface

// File: rtl/fetch_resp_fifo.sv
// In-order first-word-fall-through queue holding finished fetch responses.
//   clk      clock
//   clear    synchronous clear of both pointers (reset or flush)
//   push     write wr_data (ignored when full)
//   wr_data  entry to enqueue
//   pop      drop the head entry (ignored when empty)
//   rd_data  head entry, all-zero while empty
//   full     DEPTH entries held
//   empty    no entries held
//   count    number of entries held
module fetch_resp_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     clear,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = DEPTH[PTR_W:0];

    logic [WIDTH-1:0] store [DEPTH];
    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Pointers carry one extra wrap bit so full and empty stay distinct.
    assign count   = wr_ptr - rd_ptr;
    assign empty   = (count == '0);
    assign full    = (count == FULL_COUNT);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rd_data = empty ? '0 : store[rd_ptr[PTR_W-1:0]];

    always_ff @(posedge clk) begin
        if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) store[wr_ptr[PTR_W-1:0]] <= wr_data;
    end

endmodule

// File: rtl/imem_fetch_responder.sv
// Instruction-memory responder: pipelined synchronous instruction RAM with a
// fixed read latency, a credit-limited in-order response queue, flush on
// redirect and a program-load write port.
//   clk  clock
//   rst  synchronous active-high reset (memory contents are kept)
//   bus  slave side of imem_fetch_responder_if (request, response, flush, load)
module imem_fetch_responder
    import mips_pkg::*;
#(
    parameter int ADDR_W     = DEFAULT_ADDR_W,
    parameter int DEPTH_LOG2 = DEFAULT_DEPTH_LOG2,
    parameter int LATENCY    = 2,
    parameter int QDEPTH     = 2
) (
    input  logic clk,
    input  logic rst,
    imem_fetch_responder_if.slave bus
);

    localparam int MEM_WORDS = 1 << DEPTH_LOG2;
    localparam int CREDIT_W  = $clog2(QDEPTH) + 1;
    localparam int ENTRY_W   = 1 + ADDR_W + INSTR_W;
    localparam logic [CREDIT_W-1:0] CREDIT_MAX = QDEPTH[CREDIT_W-1:0];

    logic [INSTR_W-1:0]  mem [MEM_WORDS];
    logic [CREDIT_W-1:0] credit;
    logic                kill;
    logic                accept;
    logic                pop;
    logic                req_oor;

    logic [LATENCY-1:0]  p_valid;
    logic [LATENCY-1:0]  p_err;
    logic [ADDR_W-1:0]   p_addr [LATENCY];
    logic [INSTR_W-1:0]  p_data [LATENCY];

    logic [ENTRY_W-1:0]  q_wr_data;
    logic [ENTRY_W-1:0]  q_rd_data;
    logic                q_full;
    logic                q_empty;
    logic [CREDIT_W-1:0] q_count;

    // Reset and flush both wipe the pipeline, queue and credit.
    assign kill    = rst | bus.flush;
    assign req_oor = (bus.req_addr >> DEPTH_LOG2) != '0;

    // Credit counts every request between accept and pop, so the queue can
    // never be asked to take more than QDEPTH entries.
    assign bus.req_ready = (credit < CREDIT_MAX) & ~kill;
    assign accept        = bus.req_valid & bus.req_ready;
    assign pop           = bus.resp_valid & bus.resp_ready & ~kill;

    // Load port; the pipeline reads with non-blocking semantics, so a fetch
    // of the address being loaded on the same edge sees the old word.
    always_ff @(posedge clk) begin
        if (bus.ld_en) mem[bus.ld_addr] <= bus.ld_data;
    end

    always_ff @(posedge clk) begin
        if (kill) begin
            credit <= '0;
        end else if (accept & ~pop) begin
            credit <= credit + 1'b1;
        end else if (pop & ~accept) begin
            credit <= credit - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (kill) begin
            p_valid <= '0;
        end else begin
            p_valid[0] <= accept;
            for (int i = 1; i < LATENCY; i++) p_valid[i] <= p_valid[i-1];
        end
    end

    // Stage 0 performs the RAM read; later stages only delay the result.
    // Out-of-range fetches never index the RAM and return a NOP.
    always_ff @(posedge clk) begin
        p_addr[0] <= bus.req_addr;
        p_err[0]  <= req_oor;
        p_data[0] <= req_oor ? NOP_INSTR : mem[bus.req_addr[DEPTH_LOG2-1:0]];
        for (int i = 1; i < LATENCY; i++) begin
            p_addr[i] <= p_addr[i-1];
            p_err[i]  <= p_err[i-1];
            p_data[i] <= p_data[i-1];
        end
    end

    assign q_wr_data = {p_err[LATENCY-1], p_addr[LATENCY-1], p_data[LATENCY-1]};

    fetch_resp_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (QDEPTH)
    ) u_resp_fifo (
        .clk     (clk),
        .clear   (kill),
        .push    (p_valid[LATENCY-1]),
        .wr_data (q_wr_data),
        .pop     (pop),
        .rd_data (q_rd_data),
        .full    (q_full),
        .empty   (q_empty),
        .count   (q_count)
    );

    // The queue reads back all-zero while empty, giving the idle output values.
    assign bus.resp_valid = ~q_empty;
    assign {bus.resp_err, bus.resp_addr, bus.resp_data} = q_rd_data;

    queue_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(p_valid[LATENCY-1] && q_full && !bus.flush));

    credit_covers_queue: assert property (@(posedge clk) disable iff (rst)
        q_count <= credit);

endmodule

// File: tb/tb_imem_fetch_responder.sv
// Directed bench for imem_fetch_responder. dut_a uses QDEPTH=4 for the
// back-to-back throughput case; dut_b uses the default QDEPTH=2 for the rest.
module tb_imem_fetch_responder;

    localparam int W = 65;  // {err, addr[31:0], data[31:0]}

    logic clk;
    logic rst;

    int n_vec = 0;
    int n_bad = 0;

    logic [W-1:0] exp_q[$];
    logic [31:0]  words [4] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};

    imem_fetch_responder_if #(.ADDR_W(32), .DEPTH_LOG2(10)) bus_a ();
    imem_fetch_responder_if #(.ADDR_W(32), .DEPTH_LOG2(10)) bus_b ();

    imem_fetch_responder #(
        .ADDR_W(32), .DEPTH_LOG2(10), .LATENCY(2), .QDEPTH(4)
    ) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a.slave)
    );

    imem_fetch_responder #(
        .ADDR_W(32), .DEPTH_LOG2(10), .LATENCY(2), .QDEPTH(2)
    ) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b.slave)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] ent(input logic err, input logic [31:0] a, input logic [31:0] d);
        return {err, a, d};
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic load_word(input logic [9:0] a, input logic [31:0] d);
        bus_a.ld_en = 1'b1; bus_a.ld_addr = a; bus_a.ld_data = d;
        bus_b.ld_en = 1'b1; bus_b.ld_addr = a; bus_b.ld_data = d;
        tick();
        bus_a.ld_en = 1'b0;
        bus_b.ld_en = 1'b0;
    endtask

    // One dut_b cycle: report whether the request handshakes, check any
    // popped response against the scoreboard, then advance to the next negedge.
    task automatic cycle_b(output logic acc);
        #1;
        acc = bus_b.req_valid && bus_b.req_ready;
        if (bus_b.resp_valid && bus_b.resp_ready && !bus_b.flush && !rst) begin
            if (exp_q.size() == 0) begin
                check("resp_spurious", W'(bus_b.resp_valid), W'(0));
            end else begin
                check("resp_word", {bus_b.resp_err, bus_b.resp_addr, bus_b.resp_data},
                      exp_q.pop_front());
            end
        end
        tick();
    endtask

    task automatic drain_b(input int cycles);
        logic acc;
        bus_b.req_valid = 1'b0;
        bus_b.resp_ready = 1'b1;
        repeat (cycles) cycle_b(acc);
        check("queue_drained", W'(exp_q.size()), W'(0));
        check("idle_resp_valid", W'(bus_b.resp_valid), W'(0));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic acc;
        int   n_acc;
        int   next_addr;

        rst = 1'b1;
        bus_a.req_valid = 1'b0; bus_a.req_addr = '0; bus_a.resp_ready = 1'b0;
        bus_a.flush = 1'b0; bus_a.ld_en = 1'b0; bus_a.ld_addr = '0; bus_a.ld_data = '0;
        bus_b.req_valid = 1'b0; bus_b.req_addr = '0; bus_b.resp_ready = 1'b0;
        bus_b.flush = 1'b0; bus_b.ld_en = 1'b0; bus_b.ld_addr = '0; bus_b.ld_data = '0;

        // Program load happens while reset is held; loads ignore reset.
        tick();
        for (int i = 0; i < 4; i++) load_word(10'(i), words[i]);
        load_word(10'd5, 32'h55555555);

        // Reset state
        #1;
        check("rst_req_ready", W'(bus_b.req_ready), W'(0));
        check("rst_resp_valid", W'(bus_b.resp_valid), W'(0));
        check("rst_resp_word", {bus_b.resp_err, bus_b.resp_addr, bus_b.resp_data}, ent(1'b0, 32'h0, 32'h0));
        check("rst_resp_valid_a", W'(bus_a.resp_valid), W'(0));
        rst = 1'b0;
        #1;
        check("post_rst_req_ready", W'(bus_b.req_ready), W'(1));
        check("post_rst_req_ready_a", W'(bus_a.req_ready), W'(1));
        @(negedge clk);

        // Back-to-back fetch of 0..3 on QDEPTH=4, resp_ready held high.
        // Accept on edges E0..E3; responses visible after E2..E5.
        bus_a.resp_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            bus_a.req_valid = (k < 4);
            bus_a.req_addr  = 32'(k);
            #1;
            if (k < 4) check("t1_req_ready", W'(bus_a.req_ready), W'(1));
            tick();
            if (k >= 2 && k <= 5) begin
                check("t1_resp_valid", W'(bus_a.resp_valid), W'(1));
                check("t1_resp_word", {bus_a.resp_err, bus_a.resp_addr, bus_a.resp_data},
                      ent(1'b0, 32'(k - 2), words[k - 2]));
            end else begin
                check("t1_resp_valid", W'(bus_a.resp_valid), W'(0));
            end
        end
        bus_a.req_valid = 1'b0;

        // Credit limit with QDEPTH=2 and no consumer: exactly two accepts.
        exp_q.push_back(ent(1'b0, 32'd0, 32'h11111111));
        exp_q.push_back(ent(1'b0, 32'd1, 32'h22222222));
        bus_b.resp_ready = 1'b0;
        bus_b.req_valid  = 1'b1;
        n_acc = 0;
        next_addr = 0;
        for (int k = 0; k < 6; k++) begin
            bus_b.req_addr = 32'(next_addr);
            cycle_b(acc);
            if (acc) begin
                n_acc++;
                next_addr++;
            end
        end
        check("t2_accepts", W'(n_acc), W'(2));
        #1;
        check("t2_req_ready_full", W'(bus_b.req_ready), W'(0));
        check("t2_head_held", {bus_b.resp_err, bus_b.resp_addr, bus_b.resp_data}, ent(1'b0, 32'd0, 32'h11111111));
        bus_b.resp_ready = 1'b1;
        bus_b.req_addr   = 32'(next_addr);
        #1;
        check("t2_req_ready_before_pop", W'(bus_b.req_ready), W'(0));
        cycle_b(acc);
        check("t2_no_accept_at_pop", W'(acc), W'(0));
        #1;
        check("t2_req_ready_after_pop", W'(bus_b.req_ready), W'(1));
        drain_b(6);

        // Out-of-range address, then an in-range one.
        exp_q.push_back(ent(1'b1, 32'h00000400, 32'h00000000));
        exp_q.push_back(ent(1'b0, 32'd5, 32'h55555555));
        bus_b.resp_ready = 1'b1;
        bus_b.req_valid  = 1'b1;
        bus_b.req_addr   = 32'h00000400;
        cycle_b(acc);
        check("t3_accept_oor", W'(acc), W'(1));
        bus_b.req_addr = 32'd5;
        cycle_b(acc);
        check("t3_accept_5", W'(acc), W'(1));
        drain_b(6);

        // Flush with two requests in flight.
        bus_b.req_valid = 1'b1;
        bus_b.req_addr  = 32'd0;
        cycle_b(acc);
        check("t4_accept_0", W'(acc), W'(1));
        bus_b.req_addr = 32'd1;
        cycle_b(acc);
        check("t4_accept_1", W'(acc), W'(1));
        bus_b.req_addr = 32'd3;
        bus_b.flush    = 1'b1;
        #1;
        check("t4_req_ready_flush", W'(bus_b.req_ready), W'(0));
        cycle_b(acc);
        bus_b.flush     = 1'b0;
        bus_b.req_valid = 1'b0;
        check("t4_resp_valid_after", W'(bus_b.resp_valid), W'(0));
        #1;
        check("t4_req_ready_after", W'(bus_b.req_ready), W'(1));
        exp_q.push_back(ent(1'b0, 32'd2, 32'h33333333));
        bus_b.req_valid = 1'b1;
        bus_b.req_addr  = 32'd2;
        cycle_b(acc);
        check("t4_accept_2", W'(acc), W'(1));
        drain_b(6);

        // Load and fetch of the same word on one edge: old data returned.
        exp_q.push_back(ent(1'b0, 32'd1, 32'h22222222));
        exp_q.push_back(ent(1'b0, 32'd1, 32'hDEADBEEF));
        bus_b.ld_en     = 1'b1;
        bus_b.ld_addr   = 10'd1;
        bus_b.ld_data   = 32'hDEADBEEF;
        bus_b.req_valid = 1'b1;
        bus_b.req_addr  = 32'd1;
        cycle_b(acc);
        check("t5_accept_collide", W'(acc), W'(1));
        bus_b.ld_en = 1'b0;
        cycle_b(acc);
        check("t5_accept_after", W'(acc), W'(1));
        drain_b(6);

        // Reset with two queued responses; memory survives.
        bus_b.resp_ready = 1'b0;
        bus_b.req_valid  = 1'b1;
        bus_b.req_addr   = 32'd0;
        cycle_b(acc);
        bus_b.req_addr = 32'd1;
        cycle_b(acc);
        bus_b.req_valid = 1'b0;
        repeat (3) cycle_b(acc);
        check("t6_queued_valid", W'(bus_b.resp_valid), W'(1));
        rst = 1'b1;
        cycle_b(acc);
        #1;
        check("t6_resp_valid_rst", W'(bus_b.resp_valid), W'(0));
        check("t6_resp_word_rst", {bus_b.resp_err, bus_b.resp_addr, bus_b.resp_data}, ent(1'b0, 32'h0, 32'h0));
        check("t6_req_ready_rst", W'(bus_b.req_ready), W'(0));
        rst = 1'b0;
        @(negedge clk);
        exp_q.push_back(ent(1'b0, 32'd0, 32'h11111111));
        bus_b.resp_ready = 1'b1;
        bus_b.req_valid  = 1'b1;
        bus_b.req_addr   = 32'd0;
        cycle_b(acc);
        check("t6_accept_after_rst", W'(acc), W'(1));
        drain_b(6);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/imem_fetch_responder.md
Name: imem_fetch_responder

Overview:
- Instruction-memory responder on the far side of the fetch interface: takes word addresses from the program counter / fetch stage and returns 32-bit instruction words.
- Models a pipelined synchronous instruction RAM with fixed read latency, a credit-limited response queue, backpressure and flush on branch redirect.
- Includes a program-load write port so test benches and boot logic can fill the memory.

Parameters:
ADDR_W, 32, request address width; addresses are word addresses, sequential fetch is +1
DEPTH_LOG2, 10, log2 of memory depth in 32-bit words (1024 words)
LATENCY, 2, cycles from request accept to response entering the queue (1..4)
QDEPTH, 2, max requests in flight plus queued responses (power of 2, 2..8)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
req_valid  in  1  fetch request valid
req_ready  out  1  responder can accept a request this cycle
req_addr  in  ADDR_W  word address to fetch
resp_valid  out  1  response word available
resp_ready  in  1  consumer takes response this cycle
resp_data  out  32  instruction word
resp_addr  out  ADDR_W  address the response belongs to
resp_err  out  1  address out of range (upper bits beyond DEPTH_LOG2 nonzero)
flush  in  1  discard all in-flight and queued responses (branch/jump redirect)
ld_en  in  1  program-load write enable
ld_addr  in  DEPTH_LOG2  program-load word address
ld_data  in  32  program-load data

Behaviour:
- Reset: req_ready=0 during the rst cycle, then 1. resp_valid=0, resp_data=0, resp_addr=0, resp_err=0. Pipeline valids, queue pointers and credit counter cleared. Memory contents are NOT reset.
- Accept: request accepted on a rising edge with req_valid&req_ready.
- Credit: credit counter = in-flight + queued entries. req_ready = (credit < QDEPTH) & ~flush & ~rst. Credit increments on accept and decrements on response pop (resp_valid&resp_ready). Both in the same cycle leave it unchanged.
- Pipeline: accepted request enters a LATENCY-deep shift pipeline (valid, addr, err). Memory read happens in stage 1, so data is registered. The last stage pushes {data, addr, err} into the response queue. Credit guarantees the queue never overflows.
- Latency: with an empty queue, resp_valid rises exactly LATENCY cycles after the accept edge. One request per cycle is sustained when QDEPTH > LATENCY and resp_ready is held high.
- Response queue: FIFO of QDEPTH entries, in-order, first-word-fall-through. resp_* is stable while resp_valid & ~resp_ready.
- Out of range: if req_addr[ADDR_W-1:DEPTH_LOG2] != 0, then resp_data=32'h00000000 (NOP) and resp_err=1. No memory index wrap.
- Flush:
  - Same edge clears all pipeline valids, the queue and credit.
  - resp_valid=0 the next cycle.
  - A request presented in the flush cycle is not accepted (req_ready=0).
  - A pop in the flush cycle is void.
  - req_ready returns to 1 the cycle after.
- Load port: ld_en writes mem[ld_addr] on the edge. A read of the same address in the same cycle returns the OLD data (read-before-write). Loads are independent of flush and credit.
- rst mid-operation behaves as flush plus output clear. Memory is kept.

Decomposition:
- Shared package mips_pkg: NOP_INSTR=32'h00000000, INSTR_W=32, default ADDR_W.
- Sub-module fetch_resp_fifo (width, depth params; push/pop/clear, full/empty, count) holds the response queue.
- Memory array and pipeline stay in the top module.

Test Plan:
- Load mem[0..3]=32'h11111111/22222222/33333333/44444444, rst, then request addr 0,1,2,3 back-to-back with resp_ready=1, QDEPTH=4 -> responses in order. First resp_valid exactly LATENCY=2 cycles after first accept, one per cycle, resp_addr matches.
- Default QDEPTH=2, resp_ready=0, continuous req_valid -> exactly 2 accepts, then req_ready=0. Raise resp_ready -> words delivered in order, req_ready reasserts the cycle after the first pop.
- Request addr 32'h00000400 (DEPTH_LOG2=10) -> resp_data=0, resp_err=1. Next request addr 5 -> resp_err=0.
- Two requests in flight, flush pulse -> no resp_valid for those, credit 0, req_ready=0 in flush cycle and 1 the next. Request addr 2 after -> only 32'h33333333 returned.
- ld_en to addr 1 with 32'hDEADBEEF on the same edge a request for addr 1 is accepted -> response 32'h22222222. Next request to addr 1 -> 32'hDEADBEEF.
- Assert rst with 2 queued responses -> resp_valid=0 the next cycle. After reset, request addr 0 -> 32'h11111111 (memory retained).
